// File: rtl/bnn_pkg.sv
// Shared types for the binary/low-precision PE datapath: operand precision codes
// and the stream sequencer state encoding.
package bnn_pkg;

  typedef enum logic [2:0] {
    PREC_1B = 3'b000,
    PREC_2B = 3'b001,
    PREC_4B = 3'b010,
    PREC_8B = 3'b011
  } prec_e;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN,
    OUTPUT
  } seq_state_e;

  // Codes with the top bit set are reserved
  function automatic logic PREC_IS_LEGAL(input logic [2:0] p);
    return !p[2];
  endfunction

endpackage

// File: rtl/pe_stream_sequencer.sv
// Feeds one adaptive_pe from a job descriptor plus a weight/activation stream,
// and returns the PE's accumulated dot product on a valid/ready result port.
module pe_stream_sequencer
  import bnn_pkg::*;
#(
  parameter int WORD_SIZE  = 64,
  parameter int ACC_WIDTH  = 20,
  parameter int LEN_WIDTH  = 8,
  parameter int PE_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [2:0]           cfg_precision,
  input  logic [LEN_WIDTH-1:0] cfg_len,
  input  logic [WORD_SIZE-1:0] cfg_mask,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [WORD_SIZE-1:0] s_weight,
  input  logic [WORD_SIZE-1:0] s_activation,
  output logic                 pe_ce,
  output logic                 pe_accumulate,
  output logic [2:0]           pe_precision_mode,
  output logic [WORD_SIZE-1:0] pe_weight,
  output logic [WORD_SIZE-1:0] pe_activation,
  output logic [WORD_SIZE-1:0] pe_mask,
  input  logic [ACC_WIDTH-1:0] pe_sum,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [ACC_WIDTH-1:0] m_sum,
  output logic [2:0]           m_precision,
  output logic                 cfg_err,
  output logic                 busy
);

  localparam int DRAIN_W = (PE_LATENCY < 2) ? 1 : $clog2(PE_LATENCY + 1);
  localparam logic [LEN_WIDTH-1:0] LEN_ONE   = LEN_WIDTH'(1);
  localparam logic [DRAIN_W-1:0]   DRAIN_ONE = DRAIN_W'(1);
  localparam logic [DRAIN_W-1:0]   DRAIN_INIT = DRAIN_W'(PE_LATENCY);

  seq_state_e           state_reg, state_next;
  prec_e                prec_reg;
  logic [WORD_SIZE-1:0] mask_reg;
  logic [LEN_WIDTH-1:0] len_reg;
  logic [LEN_WIDTH-1:0] beat_cnt_reg;
  logic [DRAIN_W-1:0]   drain_cnt_reg;
  logic [ACC_WIDTH-1:0] m_sum_reg;
  logic [2:0]           m_prec_reg;
  logic                 cfg_err_reg;

  logic cfg_hs, cfg_legal, s_hs, last_beat, drain_done;

  assign cfg_legal  = PREC_IS_LEGAL(cfg_precision);
  assign cfg_hs     = cfg_valid & cfg_ready;
  assign s_hs       = s_valid & s_ready;
  assign last_beat  = s_hs && (beat_cnt_reg == len_reg - LEN_ONE);
  assign drain_done = (drain_cnt_reg == DRAIN_ONE);

  always_comb begin
    state_next = state_reg;
    cfg_ready  = 1'b0;
    s_ready    = 1'b0;
    m_valid    = 1'b0;
    case (state_reg)
      IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid && cfg_legal)
          state_next = (cfg_len == '0) ? OUTPUT : STREAM;
      end
      STREAM: begin
        s_ready = 1'b1;
        if (last_beat) state_next = DRAIN;
      end
      DRAIN: begin
        if (drain_done) state_next = OUTPUT;
      end
      OUTPUT: begin
        m_valid = 1'b1;
        if (m_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      prec_reg      <= PREC_1B;
      mask_reg      <= '0;
      len_reg       <= '0;
      beat_cnt_reg  <= '0;
      drain_cnt_reg <= '0;
      m_sum_reg     <= '0;
      m_prec_reg    <= '0;
      cfg_err_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cfg_err_reg <= cfg_hs && !cfg_legal;
      case (state_reg)
        IDLE: begin
          // Rejected descriptors leave the PE-facing job fields untouched
          if (cfg_hs && cfg_legal) begin
            prec_reg     <= prec_e'(cfg_precision);
            mask_reg     <= cfg_mask;
            len_reg      <= cfg_len;
            beat_cnt_reg <= '0;
            if (cfg_len == '0) begin
              m_sum_reg  <= '0;
              m_prec_reg <= cfg_precision;
            end
          end
        end
        STREAM: begin
          if (s_hs) beat_cnt_reg <= beat_cnt_reg + LEN_ONE;
          if (last_beat) drain_cnt_reg <= DRAIN_INIT;
        end
        DRAIN: begin
          drain_cnt_reg <= drain_cnt_reg - DRAIN_ONE;
          if (drain_done) begin
            m_sum_reg  <= pe_sum;
            m_prec_reg <= prec_reg;
          end
        end
        default: ;
      endcase
    end
  end

  assign pe_ce             = s_hs;
  assign pe_accumulate     = (state_reg == STREAM) && (beat_cnt_reg != '0);
  assign pe_precision_mode = prec_reg;
  assign pe_mask           = mask_reg;
  assign pe_weight         = s_weight;
  assign pe_activation     = s_activation;
  assign m_sum             = m_sum_reg;
  assign m_precision       = m_prec_reg;
  assign cfg_err           = cfg_err_reg;
  assign busy              = (state_reg != IDLE);

endmodule

// File: tb/tb_pe_stream_sequencer.sv
// Bench for pe_stream_sequencer driving a behavioural lane-multiply PE; a job-level
// scoreboard checks every PE beat and every returned result.
module tb_pe_stream_sequencer;

  localparam int WS = 64;
  localparam int AW = 20;
  localparam int LW = 8;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic          clk = 1'b0;
  logic          reset;
  logic          cfg_valid, cfg_ready;
  logic [2:0]    cfg_precision;
  logic [LW-1:0] cfg_len;
  logic [WS-1:0] cfg_mask;
  logic          s_valid, s_ready;
  logic [WS-1:0] s_weight, s_activation;
  logic          pe_ce, pe_accumulate;
  logic [2:0]    pe_precision_mode;
  logic [WS-1:0] pe_weight, pe_activation, pe_mask;
  logic [AW-1:0] pe_sum;
  logic          m_valid, m_ready;
  logic [AW-1:0] m_sum;
  logic [2:0]    m_precision;
  logic          cfg_err, busy;

  always #5 clk = ~clk;

  pe_stream_sequencer #(.WORD_SIZE(WS), .ACC_WIDTH(AW), .LEN_WIDTH(LW), .PE_LATENCY(1)) dut (
    .clk(clk), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_precision(cfg_precision),
    .cfg_len(cfg_len), .cfg_mask(cfg_mask),
    .s_valid(s_valid), .s_ready(s_ready), .s_weight(s_weight), .s_activation(s_activation),
    .pe_ce(pe_ce), .pe_accumulate(pe_accumulate), .pe_precision_mode(pe_precision_mode),
    .pe_weight(pe_weight), .pe_activation(pe_activation), .pe_mask(pe_mask),
    .pe_sum(pe_sum),
    .m_valid(m_valid), .m_ready(m_ready), .m_sum(m_sum), .m_precision(m_precision),
    .cfg_err(cfg_err), .busy(busy)
  );

  // Sum over lanes of unsigned weight*activation, lanes 2^prec bits wide
  function automatic logic [AW-1:0] pe_dot(input logic [2:0] prec, input logic [63:0] wv,
                                            input logic [63:0] av, input logic [63:0] mask);
    int width, lanes;
    logic [63:0] s, lm, wl, al, wm, am;
    width = 1 << prec;
    lanes = 64 / width;
    lm = (64'd1 << width) - 64'd1;
    wm = wv & mask;
    am = av & mask;
    s = '0;
    for (int i = 0; i < lanes; i++) begin
      wl = (wm >> (i * width)) & lm;
      al = (am >> (i * width)) & lm;
      s = s + wl * al;
    end
    return s[AW-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (reset) pe_sum <= '0;
    else if (pe_ce)
      pe_sum <= (pe_accumulate ? pe_sum : '0) + pe_dot(pe_precision_mode, pe_weight, pe_activation, pe_mask);
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [63:0] w;
    logic [63:0] a;
    logic        acc;
    logic [2:0]  prec;
    logic [63:0] mask;
  } beat_t;
  typedef struct {
    logic [63:0] sum;
    logic [2:0]  prec;
  } res_t;

  beat_t exp_beats[$];
  res_t  exp_res[$];
  beat_t cmp_b;
  int    ce_total = 0;

  logic [2:0]  cur_prec;
  logic [63:0] cur_mask;
  logic [63:0] job_sum;
  int          beat_idx;

  always @(negedge clk) begin
    if (!reset) begin
      check("pe_ce_rule", pe_ce, s_valid & s_ready);
      check("busy_vs_idle", busy, !cfg_ready);
      if (pe_ce) begin
        ce_total++;
        if (exp_beats.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_pe_ce: got 1 expected 0");
        end else begin
          cmp_b = exp_beats.pop_front();
          check("pe_weight", pe_weight, cmp_b.w);
          check("pe_activation", pe_activation, cmp_b.a);
          check("pe_accumulate", pe_accumulate, cmp_b.acc);
          check("pe_precision_mode", pe_precision_mode, cmp_b.prec);
          check("pe_mask", pe_mask, cmp_b.mask);
        end
      end
      if (m_valid) begin
        check("output_cfg_ready", cfg_ready, 0);
        check("output_s_ready", s_ready, 0);
        if (exp_res.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_m_valid: got 1 expected 0");
        end else begin
          check("m_sum_model", m_sum, exp_res[0].sum);
          check("m_precision_model", m_precision, exp_res[0].prec);
          if (m_ready) void'(exp_res.pop_front());
        end
      end
    end
  end

  task automatic send_cfg(input logic [2:0] p, input logic [7:0] len, input logic [63:0] mask);
    int n;
    cfg_valid = 1'b1; cfg_precision = p; cfg_len = len; cfg_mask = mask;
    n = 0;
    @(negedge clk);
    while (!cfg_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin checks++; errors++; $display("FAIL cfg_timeout: got no cfg_ready expected 1"); end
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    if (!p[2]) begin cur_prec = p; cur_mask = mask; job_sum = '0; beat_idx = 0; end
    $display("cfg: prec=%0d len=%0d mask=%h", p, len, mask);
  endtask

  task automatic send_beat(input logic [63:0] wv, input logic [63:0] av, input int gap);
    int n;
    repeat (gap) begin @(posedge clk); #1; end
    exp_beats.push_back('{w: wv, a: av, acc: (beat_idx != 0), prec: cur_prec, mask: cur_mask});
    s_valid = 1'b1; s_weight = wv; s_activation = av;
    n = 0;
    @(negedge clk);
    while (!s_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin checks++; errors++; $display("FAIL beat_timeout: got no s_ready expected 1"); end
    @(posedge clk); #1;
    s_valid = 1'b0;
    job_sum = job_sum + 64'(pe_dot(cur_prec, wv, av, cur_mask));
    beat_idx++;
    $display("beat: idx=%0d w=%h a=%h", beat_idx - 1, wv, av);
  endtask

  task automatic wait_result(input logic [63:0] lit, input int ready_delay, output int lat);
    exp_res.push_back('{sum: job_sum, prec: cur_prec});
    lat = 0;
    do begin @(negedge clk); lat++; end while (!m_valid && lat < 50);
    if (!m_valid) begin
      checks++; errors++;
      $display("FAIL result_timeout: got m_valid=0 expected 1");
      void'(exp_res.pop_back());
      @(posedge clk); #1;
      return;
    end
    check("m_sum_literal", m_sum, lit);
    for (int i = 0; i < ready_delay; i++) begin
      @(negedge clk);
      check("hold_m_valid", m_valid, 1);
      check("hold_m_sum", m_sum, lit);
      check("hold_cfg_ready", cfg_ready, 0);
      check("hold_s_ready", s_ready, 0);
    end
    @(posedge clk); #1;
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    $display("result: sum=%0d prec=%0d latency=%0d", m_sum, m_precision, lat);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_cfg_ready"}, cfg_ready, 1);
    check({tag, "_s_ready"}, s_ready, 0);
    check({tag, "_pe_ce"}, pe_ce, 0);
    check({tag, "_pe_accumulate"}, pe_accumulate, 0);
    check({tag, "_m_valid"}, m_valid, 0);
    check({tag, "_cfg_err"}, cfg_err, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_m_sum"}, m_sum, 0);
    check({tag, "_m_precision"}, m_precision, 0);
    check({tag, "_pe_precision_mode"}, pe_precision_mode, 0);
    check({tag, "_pe_mask"}, pe_mask, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, ce0;
    reset = 1'b1; cfg_valid = 1'b0; cfg_precision = '0; cfg_len = '0; cfg_mask = '0;
    s_valid = 1'b0; s_weight = '0; s_activation = '0; m_ready = 1'b0;
    cur_prec = '0; cur_mask = '0; job_sum = '0; beat_idx = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset_state("reset");
    @(posedge clk); #1;

    // 1: 1-bit, three back-to-back beats, 32 per beat
    send_cfg(3'b000, 8'd3, ONES);
    repeat (3) send_beat(ONES, 64'hAAAA_AAAA_AAAA_AAAA, 0);
    wait_result(64'd96, 0, lat);
    check("t1_latency", lat, 2);
    @(negedge clk);
    check("t1_idle_after", m_valid, 0);
    @(posedge clk); #1;

    // 2: 2-bit with a 3-cycle gap, 3*2*32 per beat
    ce0 = ce_total;
    send_cfg(3'b001, 8'd2, ONES);
    send_beat(ONES, 64'hAAAA_AAAA_AAAA_AAAA, 0);
    send_beat(ONES, 64'hAAAA_AAAA_AAAA_AAAA, 3);
    wait_result(64'd384, 0, lat);
    check("t2_ce_count", ce_total - ce0, 2);

    // 3: 8-bit with 5 cycles of backpressure, 255*128*8 per beat
    send_cfg(3'b011, 8'd2, ONES);
    repeat (2) send_beat(ONES, 64'h8080_8080_8080_8080, 0);
    wait_result(64'd522240, 5, lat);
    check("t3_m_precision", m_precision, 3'b011);

    // 4: empty job
    ce0 = ce_total;
    send_cfg(3'b010, 8'd0, 64'h0F0F_0F0F_0F0F_0F0F);
    wait_result(64'd0, 0, lat);
    check("t4_latency", lat, 1);
    check("t4_ce_count", ce_total - ce0, 0);
    check("t4_pe_mask_idle", pe_mask, 64'h0F0F_0F0F_0F0F_0F0F);
    check("t4_pe_prec_idle", pe_precision_mode, 3'b010);

    // 5: illegal precision
    send_cfg(3'b101, 8'd2, ONES);
    @(negedge clk);
    check("t5_cfg_err_pulse", cfg_err, 1);
    check("t5_cfg_ready", cfg_ready, 1);
    check("t5_busy", busy, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t5_cfg_err_cleared", cfg_err, 0);
      check("t5_busy_after", busy, 0);
      check("t5_no_m_valid", m_valid, 0);
    end
    @(posedge clk); #1;

    // 6: reset after first beat of a 3-beat job, then a fresh 4-bit job
    send_cfg(3'b000, 8'd3, ONES);
    send_beat(ONES, 64'hAAAA_AAAA_AAAA_AAAA, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_beats.delete();
    exp_res.delete();
    @(negedge clk);
    check_reset_state("midjob_reset");
    @(posedge clk); #1;
    send_cfg(3'b010, 8'd2, ONES);
    repeat (2) send_beat(ONES, 64'h8888_8888_8888_8888, 0);
    wait_result(64'd3840, 0, lat);
    check("t6_latency", lat, 2);

    repeat (2) @(posedge clk);
    check("queues_drained", 64'(exp_beats.size() + exp_res.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
